pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register for the MIPS pipeline (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_skid.sv | 99 +++++++++
 tb/tb_pipe_stage_skid.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake,
// optional one-entry skid buffer, branch flush and exception flush.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0] EXC_PC = PC_W'(32'h0000_4180),
  parameter bit SKID = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              skid_full
);

  logic              mv;
  logic [PC_W-1:0]   mpc;
  logic [DATA_W-1:0] mdata;
  logic              sv;
  logic [PC_W-1:0]   spc;
  logic [DATA_W-1:0] sdata;
  logic              take;
  logic              acc;

  assign take = !mv || out_ready;
  // With a skid entry, in_ready is a flop output so out_ready never reaches it.
  assign in_ready = SKID ? !sv : take;
  assign acc = in_valid && in_ready;

  assign out_valid = mv;
  assign out_pc = mpc;
  assign out_data = mdata;
  assign skid_full = sv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mv <= 1'b0;
      mpc <= RESET_PC;
      mdata <= '0;
    end else if (req) begin
      mv <= 1'b0;
      mpc <= EXC_PC;
      mdata <= '0;
    end else if (flush) begin
      mv <= 1'b0;
      mdata <= '0;
    end else if (take) begin
      if (sv) begin
        mv <= 1'b1;
        mpc <= spc;
        mdata <= sdata;
      end else if (acc) begin
        mv <= 1'b1;
        mpc <= in_pc;
        mdata <= in_data;
      end else begin
        mv <= 1'b0;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sv <= 1'b0;
          spc <= '0;
          sdata <= '0;
        end else if (req || flush) begin
          sv <= 1'b0;
        end else if (take) begin
          sv <= sv && acc;
          if (sv && acc) begin
            spc <= in_pc;
            sdata <= in_data;
          end
        end else if (acc) begin
          sv <= 1'b1;
          spc <= in_pc;
          sdata <= in_data;
        end
      end
    end else begin : g_flat
      assign sv = 1'b0;
      assign spc = '0;
      assign sdata = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1/128-bit stage
// and one SKID=0/64-bit stage, checked against a FIFO model.
module tb_pipe_stage_skid;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iv[2];
  logic         ordy[2];
  logic         fl[2];
  logic         rq[2];
  logic [31:0]  ipc[2];
  logic [127:0] idat[2];
  logic         ir[2];
  logic         ov[2];
  logic         sf[2];
  logic [31:0]  opc[2];
  logic [63:0]  od0;
  logic [127:0] od1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .SKID(1'b0)) u_flat (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_pc(ipc[0]), .in_data(idat[0][63:0]),
    .flush(fl[0]), .req(rq[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_pc(opc[0]), .out_data(od0),
    .skid_full(sf[0])
  );

  pipe_stage_skid #(.DATA_W(128), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_pc(ipc[1]), .in_data(idat[1]),
    .flush(fl[1]), .req(rq[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_pc(opc[1]), .out_data(od1),
    .skid_full(sf[1])
  );

  function automatic logic [127:0] dat_of(input int k);
    return (k == 0) ? {64'b0, od0} : od1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: accepted beats form a FIFO; flush/req empty it.
  for (genvar k = 0; k < 2; k++) begin : g_mon
    beat_t        q[$];
    logic [31:0]  hpc;
    logic [127:0] hdat;
    bit           hchk;
    int           acc = 0;
    int           dlv = 0;
    always @(negedge clk) begin
      int n;
      beat_t b;
      logic [127:0] msk;
      bit exp_ir;
      msk = (k == 0) ? {64'b0, {64{1'b1}}} : {128{1'b1}};
      if (reset) begin
        q.delete();
        hpc = RST_PC;
        hdat = '0;
        hchk = 1'b1;
      end else begin
        n = q.size();
        exp_ir = (k == 1) ? (n < 2) : (n == 0 || ordy[k]);
        chk($sformatf("valid%0d", k), 128'(ov[k]), 128'(n > 0));
        chk($sformatf("skid_full%0d", k), 128'(sf[k]),
            128'((k == 1) && (n == 2)));
        chk($sformatf("in_ready%0d", k), 128'(ir[k]), 128'(exp_ir));
        if (n > 0) begin
          hpc = q[0].pc;
          hdat = q[0].data;
        end else if (hchk) begin
          chk($sformatf("idle_pc%0d", k), 128'(opc[k]), 128'(hpc));
          chk($sformatf("idle_data%0d", k), dat_of(k), hdat);
        end
        if (ov[k] && ordy[k] && n > 0) begin
          b = q.pop_front();
          dlv++;
          chk($sformatf("out_pc%0d", k), 128'(opc[k]), 128'(b.pc));
          chk($sformatf("out_data%0d", k), dat_of(k), b.data);
        end
        if (rq[k]) begin
          q.delete();
          hpc = EXC_PC;
          hdat = '0;
          hchk = 1'b1;
        end else if (fl[k]) begin
          q.delete();
          hdat = '0;
          hchk = 1'b1;
        end else if (iv[k] && ir[k]) begin
          q.push_back('{ipc[k], idat[k] & msk});
          acc++;
          hchk = 1'b0;
        end
      end
    end
  end

  initial begin
    int a0;
    int d0;
    int ncyc;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ordy[k] = 0; fl[k] = 0; rq[k] = 0;
      ipc[k] = '0; idat[k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 128'(ov[k]), 128'(0));
      chk("rst_pc", 128'(opc[k]), 128'(RST_PC));
      chk("rst_data", dat_of(k), 128'(0));
      chk("rst_in_ready", 128'(ir[k]), 128'(1));
      chk("rst_skid_full", 128'(sf[k]), 128'(0));
    end

    // Streaming with out_ready high: one-cycle latency, in order.
    for (int k = 0; k < 2; k++) ordy[k] = 1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1;
        ipc[k] = 32'h3000 + 32'(4 * i);
        idat[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk("lat_valid", 128'(ov[k]), 128'(1));
        chk("lat_pc", 128'(opc[k]), 128'(32'h3000 + 32'(4 * i)));
      end
    end
    for (int k = 0; k < 2; k++) iv[k] = 0;
    cyc(); cyc();

    // Back-pressure fills main then skid.
    ordy[1] = 0; iv[1] = 1; ipc[1] = 32'h100; idat[1] = 128'hA;
    cyc();
    ipc[1] = 32'h104; idat[1] = 128'hB;
    cyc();
    chk("bp_skid_full", 128'(sf[1]), 128'(1));
    chk("bp_in_ready", 128'(ir[1]), 128'(0));
    chk("bp_main_pc", 128'(opc[1]), 128'(32'h100));
    ipc[1] = 32'h108; idat[1] = 128'hC;
    cyc();
    chk("bp_refuse_pc", 128'(opc[1]), 128'(32'h100));
    iv[1] = 0; ordy[1] = 1;
    cyc();
    chk("bp_b_pc", 128'(opc[1]), 128'(32'h104));
    chk("bp_b_data", od1, 128'hB);
    chk("bp_skid_clr", 128'(sf[1]), 128'(0));
    chk("bp_ready_back", 128'(ir[1]), 128'(1));
    cyc();
    chk("bp_drained", 128'(ov[1]), 128'(0));

    // Exception with both entries full.
    ordy[1] = 0; iv[1] = 1; ipc[1] = 32'h200; idat[1] = 128'h20;
    cyc();
    ipc[1] = 32'h204; idat[1] = 128'h21;
    cyc();
    chk("exc_pre_full", 128'(sf[1]), 128'(1));
    rq[1] = 1; ipc[1] = 32'h208;
    cyc();
    rq[1] = 0; iv[1] = 0;
    chk("exc_valid", 128'(ov[1]), 128'(0));
    chk("exc_pc", 128'(opc[1]), 128'(EXC_PC));
    chk("exc_data", od1, 128'(0));
    chk("exc_skid", 128'(sf[1]), 128'(0));
    chk("exc_in_ready", 128'(ir[1]), 128'(1));
    cyc();

    // flush+req together: req wins, accepted-able input dropped.
    iv[1] = 1; ipc[1] = 32'h300; idat[1] = 128'h30;
    cyc();
    fl[1] = 1; rq[1] = 1; ipc[1] = 32'h304;
    cyc();
    fl[1] = 0; rq[1] = 0; iv[1] = 0;
    chk("fr_valid", 128'(ov[1]), 128'(0));
    chk("fr_pc", 128'(opc[1]), 128'(EXC_PC));
    // flush alone keeps out_pc.
    iv[1] = 1; ipc[1] = 32'h310; idat[1] = 128'h31;
    cyc();
    fl[1] = 1; ipc[1] = 32'h314;
    cyc();
    fl[1] = 0; iv[1] = 0;
    chk("fl_valid", 128'(ov[1]), 128'(0));
    chk("fl_pc", 128'(opc[1]), 128'(32'h310));
    chk("fl_data", od1, 128'(0));
    cyc();
    ordy[1] = 1;

    // Random traffic; SKID=0 stage runs 1000 beats undisturbed.
    a0 = g_mon[0].acc;
    d0 = g_mon[0].dlv;
    ncyc = 0;
    while (g_mon[0].acc - a0 < 1000 && ncyc < 20000) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = ($urandom_range(9) < 7);
        ordy[k] = $urandom_range(1);
        ipc[k] = $urandom;
        idat[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      fl[1] = ($urandom_range(39) == 0);
      rq[1] = ($urandom_range(96) == 0);
      if (fl[1] || rq[1]) ordy[1] = 0;
      cyc();
      ncyc++;
    end
    chk("rand_budget", 128'(ncyc < 20000), 128'(1));
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ordy[k] = 1; fl[k] = 0; rq[k] = 0;
    end
    repeat (4) cyc();
    chk("rand_lossless", 128'(g_mon[0].dlv - d0), 128'(g_mon[0].acc - a0));

    // Asynchronous reset with a full stage.
    ordy[1] = 0; iv[1] = 1; ipc[1] = 32'h500; idat[1] = 128'h50;
    cyc();
    ipc[1] = 32'h504;
    cyc();
    iv[1] = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 128'(ov[1]), 128'(0));
    chk("arst_skid", 128'(sf[1]), 128'(0));
    chk("arst_pc", 128'(opc[1]), 128'(RST_PC));
    chk("arst_in_ready", 128'(ir[1]), 128'(1));
    cyc();
    reset = 1'b0;
    ordy[1] = 1;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
